// File: rtl/arbiter_4_masters_rr.sv
// arbiter_4_masters_rr: round-robin Wishbone arbiter sharing one slave among four masters, with a stall watchdog
module arbiter_4_masters_rr #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_m0_we,
  input  logic        i_m0_stb,
  input  logic        i_m0_cyc,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  output logic [31:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_int,
  input  logic        i_m1_we,
  input  logic        i_m1_stb,
  input  logic        i_m1_cyc,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  output logic [31:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_int,
  input  logic        i_m2_we,
  input  logic        i_m2_stb,
  input  logic        i_m2_cyc,
  input  logic [3:0]  i_m2_sel,
  input  logic [31:0] i_m2_adr,
  input  logic [31:0] i_m2_dat,
  output logic [31:0] o_m2_dat,
  output logic        o_m2_ack,
  output logic        o_m2_int,
  input  logic        i_m3_we,
  input  logic        i_m3_stb,
  input  logic        i_m3_cyc,
  input  logic [3:0]  i_m3_sel,
  input  logic [31:0] i_m3_adr,
  input  logic [31:0] i_m3_dat,
  output logic [31:0] o_m3_dat,
  output logic        o_m3_ack,
  output logic        o_m3_int,
  output logic        o_s_we,
  output logic        o_s_stb,
  output logic        o_s_cyc,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  input  logic [31:0] i_s_dat,
  input  logic        i_s_ack,
  input  logic        i_s_int,
  output logic [3:0]  o_grant,
  output logic        o_timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t      state;
  logic [3:0]  grant;
  logic [1:0]  own, last_owner, nxt;
  logic [15:0] cnt;
  logic [3:0]  cyc, stb, we;
  logic [3:0]  sel [4];
  logic [31:0] adr [4];
  logic [31:0] dat [4];
  logic        owned, timeout;

  assign cyc = {i_m3_cyc, i_m2_cyc, i_m1_cyc, i_m0_cyc};
  assign stb = {i_m3_stb, i_m2_stb, i_m1_stb, i_m0_stb};
  assign we  = {i_m3_we, i_m2_we, i_m1_we, i_m0_we};
  assign sel = '{i_m0_sel, i_m1_sel, i_m2_sel, i_m3_sel};
  assign adr = '{i_m0_adr, i_m1_adr, i_m2_adr, i_m3_adr};
  assign dat = '{i_m0_dat, i_m1_dat, i_m2_dat, i_m3_dat};

  assign owned   = state == OWNED;
  assign timeout = owned && stb[own] && !i_s_ack && cnt == 16'(TIMEOUT);

  // Round-robin search starting just after the previous owner and wrapping
  always_comb begin
    logic found;
    logic [1:0] idx;
    nxt = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_owner + i[1:0];
      if (!found && cyc[idx]) begin
        nxt = idx;
        found = 1'b1;
      end
    end
  end

  // Ownership FSM and watchdog counter; an owner keeps the bus until it drops cyc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      own <= '0;
      last_owner <= 2'd3;
      cnt <= '0;
    end else if (!owned) begin
      cnt <= '0;
      if (|cyc) begin
        state <= OWNED;
        own <= nxt;
        grant <= 4'b0001 << nxt;
      end
    end else if (!cyc[own]) begin
      state <= IDLE;
      grant <= '0;
      last_owner <= own;
      cnt <= '0;
    end else begin
      cnt <= (i_s_ack || !stb[own] || timeout) ? '0 : cnt + 16'd1;
    end
  end

  assign o_grant   = grant;
  assign o_timeout = timeout;

  assign o_s_cyc = owned && cyc[own];
  assign o_s_stb = owned && stb[own] && !timeout;
  assign o_s_we  = owned && we[own];
  assign o_s_sel = owned ? sel[own] : '0;
  assign o_s_adr = owned ? adr[own] : '0;
  assign o_s_dat = owned ? dat[own] : '0;

  assign o_m0_ack = grant[0] && (i_s_ack || timeout);
  assign o_m1_ack = grant[1] && (i_s_ack || timeout);
  assign o_m2_ack = grant[2] && (i_s_ack || timeout);
  assign o_m3_ack = grant[3] && (i_s_ack || timeout);

  assign o_m0_dat = (grant[0] && !timeout) ? i_s_dat : '0;
  assign o_m1_dat = (grant[1] && !timeout) ? i_s_dat : '0;
  assign o_m2_dat = (grant[2] && !timeout) ? i_s_dat : '0;
  assign o_m3_dat = (grant[3] && !timeout) ? i_s_dat : '0;

  assign o_m0_int = i_s_int;
  assign o_m1_int = i_s_int;
  assign o_m2_int = i_s_int;
  assign o_m3_int = i_s_int;
endmodule

// File: tb/tb_arbiter_4_masters_rr.sv
// tb_arbiter_4_masters_rr: directed vector and sequence checks for the round-robin arbiter
module tb_arbiter_4_masters_rr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] cyc = '0;
  logic [3:0] stb = '0;
  logic s_ack = 1'b0;
  logic s_int = 1'b0;
  logic [31:0] s_dat = '0;
  logic [31:0] m_dat [4];
  logic [3:0] m_ack, m_int, grant, s_sel;
  logic s_we, s_stb, s_cyc, tmo;
  logic [31:0] s_adr, s_wdat;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbiter_4_masters_rr #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_m0_we(1'b0), .i_m0_stb(stb[0]), .i_m0_cyc(cyc[0]), .i_m0_sel(4'b0001),
    .i_m0_adr(32'h1000_0000), .i_m0_dat(32'hD000_0000),
    .o_m0_dat(m_dat[0]), .o_m0_ack(m_ack[0]), .o_m0_int(m_int[0]),
    .i_m1_we(1'b1), .i_m1_stb(stb[1]), .i_m1_cyc(cyc[1]), .i_m1_sel(4'b0010),
    .i_m1_adr(32'h1000_0001), .i_m1_dat(32'hD000_0001),
    .o_m1_dat(m_dat[1]), .o_m1_ack(m_ack[1]), .o_m1_int(m_int[1]),
    .i_m2_we(1'b0), .i_m2_stb(stb[2]), .i_m2_cyc(cyc[2]), .i_m2_sel(4'b0100),
    .i_m2_adr(32'h1000_0002), .i_m2_dat(32'hD000_0002),
    .o_m2_dat(m_dat[2]), .o_m2_ack(m_ack[2]), .o_m2_int(m_int[2]),
    .i_m3_we(1'b1), .i_m3_stb(stb[3]), .i_m3_cyc(cyc[3]), .i_m3_sel(4'b1000),
    .i_m3_adr(32'h1000_0003), .i_m3_dat(32'hD000_0003),
    .o_m3_dat(m_dat[3]), .o_m3_ack(m_ack[3]), .o_m3_int(m_int[3]),
    .o_s_we(s_we), .o_s_stb(s_stb), .o_s_cyc(s_cyc), .o_s_sel(s_sel),
    .o_s_adr(s_adr), .o_s_dat(s_wdat),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_int(s_int),
    .o_grant(grant), .o_timeout(tmo)
  );

  typedef struct {
    logic [3:0] cyc, stb;
    logic ack, sint;
    logic [31:0] sdat;
    logic [3:0] g;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic a, input logic i, input logic [31:0] d);
    @(negedge clk);
    cyc = c;
    stb = s;
    s_ack = a;
    s_int = i;
    s_dat = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = '0;
    stb = '0;
    s_ack = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int idx_of(input logic [3:0] g);
    return g[1] ? 1 : g[2] ? 2 : g[3] ? 3 : 0;
  endfunction

  initial begin
    int k;
    logic [3:0] g;
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000};
    tbl[1]  = '{4'b0101, 4'b0101, 1'b0, 1'b1, 32'h0,         4'b0000};
    tbl[2]  = '{4'b0101, 4'b0101, 1'b0, 1'b0, 32'h1234_5678, 4'b0001};
    tbl[3]  = '{4'b0101, 4'b0101, 1'b1, 1'b1, 32'hA5A5_0001, 4'b0001};
    tbl[4]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0,         4'b0001};
    tbl[5]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0,         4'b0000};
    tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 32'h5555_AAAA, 4'b0100};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0,         4'b0100};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000};
    tbl[9]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0,         4'b0000};
    tbl[10] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 32'hCAFE_F00D, 4'b0010};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0010};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000};

    s_int = 1'b1;
    #2;
    chk("reset_grant", 32'(grant), 0);
    chk("reset_s_cyc", 32'(s_cyc), 0);
    chk("reset_timeout", 32'(tmo), 0);
    chk("reset_int", 32'(m_int), 32'hF);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].cyc, tbl[v].stb, tbl[v].ack, tbl[v].sint, tbl[v].sdat);
      g = tbl[v].g;
      k = idx_of(g);
      chk($sformatf("v%0d_grant", v), 32'(grant), 32'(g));
      chk($sformatf("v%0d_s_cyc", v), 32'(s_cyc), 32'(|g && tbl[v].cyc[k]));
      chk($sformatf("v%0d_s_stb", v), 32'(s_stb), 32'(|g && tbl[v].stb[k]));
      chk($sformatf("v%0d_s_adr", v), s_adr, |g ? 32'h1000_0000 + 32'(k) : 32'h0);
      chk($sformatf("v%0d_s_dat", v), s_wdat, |g ? 32'hD000_0000 + 32'(k) : 32'h0);
      chk($sformatf("v%0d_s_we", v), 32'(s_we), 32'(|g && k[0]));
      chk($sformatf("v%0d_s_sel", v), 32'(s_sel), 32'(g));
      chk($sformatf("v%0d_ack", v), 32'(m_ack), tbl[v].ack ? 32'(g) : 32'h0);
      for (int n = 0; n < 4; n++)
        chk($sformatf("v%0d_m%0d_dat", v, n), m_dat[n], g[n] ? tbl[v].sdat : 32'h0);
      chk($sformatf("v%0d_int", v), 32'(m_int), tbl[v].sint ? 32'hF : 32'h0);
      chk($sformatf("v%0d_timeout", v), 32'(tmo), 0);
    end

    do_reset();
    drive(4'b1111, 4'b1111, 1'b0, 1'b0, 32'h0);
    for (int r = 0; r < 5; r++) begin
      k = r % 4;
      chk($sformatf("rr%0d_dead", r), 32'(grant), 0);
      drive(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0BAD_0000 + 32'(r));
      chk($sformatf("rr%0d_grant", r), 32'(grant), 32'(4'b0001 << k));
      chk($sformatf("rr%0d_ack", r), 32'(m_ack), 32'(4'b0001 << k));
      g = 4'b1111;
      g[k] = 1'b0;
      drive(g, g, 1'b0, 1'b0, 32'h0);
      chk($sformatf("rr%0d_hold", r), 32'(grant), 32'(4'b0001 << k));
      drive(4'b1111, 4'b1111, 1'b0, 1'b0, 32'h0);
    end

    do_reset();
    drive(4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0);
    chk("wd_idle", 32'(grant), 0);
    for (int i = 1; i <= 28; i++) begin
      logic hit;
      hit = (i == 9) || (i == 18);
      drive(4'b0100, 4'b0100, i == 27, 1'b0, 32'hBEEF_0000 + 32'(i));
      chk($sformatf("wd%0d_timeout", i), 32'(tmo), 32'(hit));
      chk($sformatf("wd%0d_ack", i), 32'(m_ack), (hit || i == 27) ? 32'h4 : 32'h0);
      chk($sformatf("wd%0d_dat", i), m_dat[2], hit ? 32'h0 : 32'hBEEF_0000 + 32'(i));
      chk($sformatf("wd%0d_s_stb", i), 32'(s_stb), 32'(!hit));
      chk($sformatf("wd%0d_grant", i), 32'(grant), 32'h4);
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

    do_reset();
    drive(4'b1000, 4'b1000, 1'b0, 1'b0, 32'h0);
    chk("ab_idle", 32'(grant), 0);
    drive(4'b1000, 4'b1000, 1'b1, 1'b1, 32'h7777_7777);
    chk("ab_grant", 32'(grant), 32'h8);
    chk("ab_s_cyc", 32'(s_cyc), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ab_rst_grant", 32'(grant), 0);
    chk("ab_rst_s_cyc", 32'(s_cyc), 0);
    chk("ab_rst_ack", 32'(m_ack), 0);
    chk("ab_rst_dat", m_dat[3], 0);
    chk("ab_rst_int", 32'(m_int), 32'hF);
    @(negedge clk);
    rst = 1'b1;
    cyc = 4'b1001;
    stb = 4'b1001;
    s_ack = 1'b0;
    #1;
    chk("ab_rel_idle", 32'(grant), 0);
    drive(4'b1001, 4'b1001, 1'b0, 1'b0, 32'h0);
    chk("ab_rel_grant", 32'(grant), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
